// File: rtl/fft_channel_arbiter_pkg.sv
// Shared types for the two-channel fft frame arbiter.
package fft_arb_pkg;

    localparam int NUM_CH = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic [0:0] chan_t;

    // Both requesting -> round-robin pointer decides; otherwise the sole requester wins.
    function automatic chan_t rr_pick(input logic req0, input logic req1, input chan_t rr_ptr);
        chan_t pick;
        if (req0 && req1) begin
            pick = rr_ptr;
        end else if (req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fft_channel_arbiter_if.sv
// Valid/ready sample stream used on every arbiter data port.
interface Axis_If #(
    parameter int DWIDTH = 24
);
    logic              valid;
    logic              ready;
    logic [DWIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fft_channel_arbiter_frame_counter.sv
// Beat counter for one fft frame: clear on grant, advance on each accepted beat.
module fft_frame_counter #(
    parameter  int FRAME_LEN = 1024,
    localparam int CW        = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The final beat returns to zero so the count never runs past FRAME_LEN-1.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_IDX);

endmodule

// File: rtl/fft_channel_arbiter.sv
// Frame-granular round-robin arbiter sharing one fft core between two sample streams.
// Define FFT_ARB_STATS_EN to add the per-channel completed-frame counters frames0/frames1.
module fft_channel_arbiter
    import fft_arb_pkg::*;
#(
    parameter int DWIDTH     = 24,
    parameter int FRAME_LEN  = 1024,
    parameter int STAT_WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    Axis_If.slave   din0,
    Axis_If.slave   din1,
    Axis_If.master  dout,
    output logic    chan,
    output logic    sof,
    output logic    frame_done,
    output logic    busy
`ifdef FFT_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] frames0,
    output logic [STAT_WIDTH-1:0] frames1
`endif
);

    localparam int CW = $clog2(FRAME_LEN);

    if (FRAME_LEN < 2 || STAT_WIDTH < 1) begin : g_param_check
        $error("fft_channel_arbiter: FRAME_LEN must be >= 2 and STAT_WIDTH >= 1");
    end

    state_t            state_q, state_d;
    chan_t             chan_q, chan_d;
    chan_t             rr_ptr_q, rr_ptr_d;
    logic              frame_done_q, frame_done_d;
    logic              cnt_clear;
    logic              cnt_last;
    logic [CW-1:0]     count;
    logic              beat;
    logic              frame_end;
    logic              out_valid;
    logic              ready0;
    logic              ready1;
    logic              sel_valid;
    logic [DWIDTH-1:0] sel_data;

    assign sel_valid = (chan_q == 1'b1) ? din1.valid : din0.valid;
    assign sel_data  = (chan_q == 1'b1) ? din1.data  : din0.data;
    assign frame_end = beat && cnt_last;

    // IDLE spends exactly one cycle arbitrating; STREAM is a zero-latency pass-through
    // of the granted channel until its frame's last beat is accepted.
    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        rr_ptr_d     = rr_ptr_q;
        frame_done_d = 1'b0;
        cnt_clear    = 1'b0;
        out_valid    = 1'b0;
        ready0       = 1'b0;
        ready1       = 1'b0;
        beat         = 1'b0;
        case (state_q)
            IDLE: begin
                if (din0.valid || din1.valid) begin
                    chan_d    = rr_pick(din0.valid, din1.valid, rr_ptr_q);
                    cnt_clear = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                out_valid = sel_valid;
                ready0    = (chan_q == 1'b0) && dout.ready;
                ready1    = (chan_q == 1'b1) && dout.ready;
                beat      = sel_valid && dout.ready;
                if (frame_end) begin
                    state_d      = IDLE;
                    rr_ptr_d     = ~chan_q;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            chan_q       <= 1'b0;
            rr_ptr_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            rr_ptr_q     <= rr_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    fft_frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (beat),
        .count  (count),
        .last   (cnt_last)
    );

`ifdef FFT_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] frames0_q, frames0_d;
    logic [STAT_WIDTH-1:0] frames1_q, frames1_d;

    // Counters wrap naturally at 2**STAT_WIDTH.
    always_comb begin
        frames0_d = frames0_q;
        frames1_d = frames1_q;
        if (frame_end) begin
            if (chan_q == 1'b0) begin
                frames0_d = frames0_q + STAT_WIDTH'(1);
            end else begin
                frames1_d = frames1_q + STAT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames0_q <= '0;
            frames1_q <= '0;
        end else begin
            frames0_q <= frames0_d;
            frames1_q <= frames1_d;
        end
    end

    assign frames0 = frames0_q;
    assign frames1 = frames1_q;
`endif

    assign din0.ready = ready0;
    assign din1.ready = ready1;
    assign dout.valid = out_valid;
    assign dout.data  = sel_data;
    assign chan       = chan_q;
    assign sof        = (count == '0) && out_valid;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == STREAM);

endmodule

// File: tb/tb_fft_channel_arbiter.sv
// Scoreboard bench for fft_channel_arbiter: random sources, a frame-level reference model
// and per-channel expected-sample queues; also checks frames0/frames1 when FFT_ARB_STATS_EN is defined.
module tb_fft_channel_arbiter;

    localparam int DWIDTH     = 24;
    localparam int FRAME_LEN  = 8;
    localparam int STAT_WIDTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    Axis_If #(.DWIDTH(DWIDTH)) din0_if ();
    Axis_If #(.DWIDTH(DWIDTH)) din1_if ();
    Axis_If #(.DWIDTH(DWIDTH)) dout_if ();

    logic chan;
    logic sof;
    logic frame_done;
    logic busy;
`ifdef FFT_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] frames0;
    logic [STAT_WIDTH-1:0] frames1;
`endif

    fft_channel_arbiter #(
        .DWIDTH     (DWIDTH),
        .FRAME_LEN  (FRAME_LEN),
        .STAT_WIDTH (STAT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din0       (din0_if),
        .din1       (din1_if),
        .dout       (dout_if),
        .chan       (chan),
        .sof        (sof),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef FFT_ARB_STATS_EN
        ,
        .frames0    (frames0),
        .frames1    (frames1)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Source knobs: valid probability per channel and ready probability, in percent.
    int          pv [2];
    int          pr;
    int unsigned seq [2];
    bit          issued [2];
    bit          acc [2];

    logic [DWIDTH-1:0] exp_q0 [$];
    logic [DWIDTH-1:0] exp_q1 [$];

    // Reference model: where the frame stands, who owns it, whose turn is next.
    bit mdl_busy;
    bit mdl_chan;
    bit mdl_rr;
    bit mdl_fd;
    int mdl_idx;
    int mdl_frames [2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one at %0t", name, $time);
    endtask

    task automatic applyStimulus(input int p0, input int p1, input int prdy, input int cycles);
        pv[0] = p0;
        pv[1] = p1;
        pr    = prdy;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic waitFrameBeat(input bit c, input int idx, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #2;
            if (mdl_busy && mdl_chan == c && mdl_idx == idx) found = 1'b1;
        end
        if (!found) timeoutFail(name);
    endtask

    // Sources: hold each sample until accepted; announce it to the scoreboard when first offered.
    always @(posedge clk) begin : driver
        logic              v;
        logic [DWIDTH-1:0] d;
        #1;
        for (int c = 0; c < 2; c++) begin
            if (acc[c]) begin
                seq[c]++;
                issued[c] = 1'b0;
            end
            v = ($urandom_range(99) < pv[c]);
            d = DWIDTH'(seq[c]);
            d[DWIDTH-1] = c[0];
            if (v && !issued[c]) begin
                if (c == 0) exp_q0.push_back(d);
                else        exp_q1.push_back(d);
                issued[c] = 1'b1;
            end
            if (c == 0) begin
                din0_if.valid = v;
                din0_if.data  = d;
            end else begin
                din1_if.valid = v;
                din1_if.data  = d;
            end
        end
        dout_if.ready = ($urandom_range(99) < pr);
    end

    // Monitor: compare every cycle against the frame model and pop the scoreboard on each beat.
    always @(negedge clk) begin : monitor
        logic              v0, v1, r, sv;
        logic [DWIDTH-1:0] exp_d;
        if (reset) begin
            mdl_busy      = 1'b0;
            mdl_chan      = 1'b0;
            mdl_rr        = 1'b0;
            mdl_fd        = 1'b0;
            mdl_idx       = 0;
            mdl_frames[0] = 0;
            mdl_frames[1] = 0;
            acc[0]        = 1'b0;
            acc[1]        = 1'b0;
        end else begin
            v0 = din0_if.valid;
            v1 = din1_if.valid;
            r  = dout_if.ready;
            checkOutput("frame_done", frame_done, mdl_fd);
            checkOutput("busy", busy, mdl_busy);
            mdl_fd = 1'b0;
            acc[0] = 1'b0;
            acc[1] = 1'b0;
            if (!mdl_busy) begin
                checkOutput("idle_dout_valid", dout_if.valid, 0);
                checkOutput("idle_din0_ready", din0_if.ready, 0);
                checkOutput("idle_din1_ready", din1_if.ready, 0);
                if (v0 || v1) begin
                    mdl_chan = (v0 && v1) ? mdl_rr : v1;
                    mdl_busy = 1'b1;
                    mdl_idx  = 0;
                end
            end else begin
                sv = mdl_chan ? v1 : v0;
                checkOutput("chan", chan, mdl_chan);
                checkOutput("dout_valid", dout_if.valid, sv);
                checkOutput("granted_ready", mdl_chan ? din1_if.ready : din0_if.ready, r);
                checkOutput("other_ready", mdl_chan ? din0_if.ready : din1_if.ready, 0);
                checkOutput("sof", sof, (mdl_idx == 0) && sv);
                if (sv && r) begin
                    acc[mdl_chan] = 1'b1;
                    if ((mdl_chan ? exp_q1.size() : exp_q0.size()) == 0) begin
                        timeoutFail("scoreboard_empty");
                    end else begin
                        exp_d = mdl_chan ? exp_q1.pop_front() : exp_q0.pop_front();
                        checkOutput("data", dout_if.data, exp_d);
                    end
                    mdl_idx++;
                    if (mdl_idx == FRAME_LEN) begin
                        mdl_busy = 1'b0;
                        mdl_rr   = ~mdl_chan;
                        mdl_fd   = 1'b1;
                        mdl_frames[mdl_chan]++;
                        mdl_idx  = 0;
                    end
                end
            end
        end
    end

    initial begin
        bit found;
        din0_if.valid = 1'b0;
        din1_if.valid = 1'b0;
        din0_if.data  = '0;
        din1_if.data  = '0;
        dout_if.ready = 1'b0;
        seq[0] = 0;
        seq[1] = 0;
        issued[0] = 1'b0;
        issued[1] = 1'b0;

        // Reset state with both sources and the sink eager.
        applyStimulus(100, 100, 100, 3);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_chan", chan, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_sof", sof, 0);
        checkOutput("rst_din0_ready", din0_if.ready, 0);
        checkOutput("rst_din1_ready", din1_if.ready, 0);
        checkOutput("rst_dout_valid", dout_if.valid, 0);
`ifdef FFT_ARB_STATS_EN
        checkOutput("rst_frames0", frames0, 0);
        checkOutput("rst_frames1", frames1, 0);
`endif
        reset = 1'b0;

        // Both always valid: ten alternating frames.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            if (mdl_frames[0] + mdl_frames[1] == 10) found = 1'b1;
        end
        if (!found) timeoutFail("ten_frames");
`ifdef FFT_ARB_STATS_EN
        checkOutput("frames0_after10", frames0, 5);
        checkOutput("frames1_after10", frames1, 5);
`endif

        // Only din1 valid, switched while ch1 owns a frame so ch0 is never granted.
        waitFrameBeat(1'b1, 2, "wait_ch1_frame");
        applyStimulus(0, 100, 100, 0);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            checkOutput("only1_din0_ready", din0_if.ready, 0);
            if (busy) checkOutput("only1_chan", chan, 1);
        end

        // Random valids and 50% backpressure.
        applyStimulus(70, 70, 50, 600);

        // Granted ch0 stalls mid-frame: no preemption by ch1.
        applyStimulus(100, 100, 100, 0);
        waitFrameBeat(1'b0, 3, "wait_ch0_beat3");
        pv[0] = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            checkOutput("stall_busy", busy, 1);
            checkOutput("stall_chan", chan, 0);
            checkOutput("stall_din1_ready", din1_if.ready, 0);
        end
        pv[0] = 100;
        waitFrameBeat(1'b1, 0, "wait_ch1_after_stall");

        // Reset at beat 5 of a ch1 frame, then ch0 must win the first grant.
        waitFrameBeat(1'b1, 5, "wait_ch1_beat5");
        checkOutput("pre_reset_valid", dout_if.valid, 1);
        reset = 1'b1;
        #1;
        checkOutput("reset_din0_ready", din0_if.ready, 0);
        checkOutput("reset_din1_ready", din1_if.ready, 0);
        checkOutput("reset_dout_valid", dout_if.valid, 0);
        checkOutput("reset_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            if (busy) found = 1'b1;
        end
        if (!found) begin
            timeoutFail("grant_after_reset");
        end else begin
            checkOutput("post_reset_chan", chan, 0);
            checkOutput("post_reset_sof", sof, 1);
        end

        applyStimulus(80, 80, 60, 200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
